// File: rtl/spi_opcode_responder.sv
// SPI mode-0 slave: receives an opcode, returns the selected channel's max value on MISO.
// Define SPI_RESP_PARITY_EN to append an even-parity bit after the data LSB.
module spi_opcode_responder #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LOAD_DLY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] max_value,
  output logic [7:0]        op_code,
  output logic              tx_ready
);

`ifdef SPI_RESP_PARITY_EN
  localparam int unsigned FRAME_W = DATA_W + 1;
`else
  localparam int unsigned FRAME_W = DATA_W;
`endif
  localparam int unsigned CNT_W = $clog2(DATA_W + 2);
  localparam int unsigned DLY_W = (LOAD_DLY > 1) ? $clog2(LOAD_DLY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LOAD,
    S_DATA,
    S_DONE,
    S_DISCARD
  } state_t;

  state_t             state, state_nx;
  logic [1:0]         sclk_sync, cs_sync, mosi_sync;
  logic               sclk_d, cs_d;
  logic               sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit;
  logic [6:0]         shift_in, shift_nx;
  logic [7:0]         op_rx, op_nx;
  logic [FRAME_W-1:0] tx_sr, tx_nx, frame_word;
  logic [CNT_W-1:0]   bit_cnt, cnt_nx;
  logic [DLY_W-1:0]   dly_cnt, dly_nx;
  logic               rdy_nx;

  // Synchronizers free-run through reset so a cs_n held low across reset never looks like a new falling edge.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[0], sclk};
    cs_sync   <= {cs_sync[0], cs_n};
    mosi_sync <= {mosi_sync[0], mosi};
    sclk_d    <= sclk_sync[1];
    cs_d      <= cs_sync[1];
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_fall   = ~cs_sync[1] & cs_d;
  assign cs_rise   = cs_sync[1] & ~cs_d;
  assign mosi_bit  = mosi_sync[1];
  assign op_rx     = {shift_in, mosi_bit};

`ifdef SPI_RESP_PARITY_EN
  assign frame_word = {max_value, ^max_value};
`else
  assign frame_word = max_value;
`endif

  always_comb begin
    state_nx = state;
    shift_nx = shift_in;
    op_nx    = op_code;
    tx_nx    = tx_sr;
    cnt_nx   = bit_cnt;
    dly_nx   = dly_cnt;
    rdy_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        op_nx = '0;
        if (cs_fall) begin
          cnt_nx   = '0;
          state_nx = S_CMD;
        end
      end
      S_CMD: begin
        if (sclk_rise) begin
          shift_nx = op_rx[6:0];
          cnt_nx   = bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(7)) begin
            op_nx    = op_rx;
            dly_nx   = '0;
            state_nx = (op_rx inside {8'h41, 8'h42, 8'h43, 8'h44}) ? S_LOAD : S_DISCARD;
          end
        end
      end
      S_LOAD: begin
        if (dly_cnt == DLY_W'(LOAD_DLY - 1)) begin
          tx_nx    = frame_word;
          cnt_nx   = '0;
          state_nx = S_DATA;
        end else begin
          dly_nx = dly_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (sclk_rise) begin
          cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
            rdy_nx   = 1'b1;
            state_nx = S_DONE;
          end
        end else if (sclk_fall && bit_cnt != '0) begin
          // The opcode's trailing falling edge lands here before any data bit was sampled; keep the MSB.
          tx_nx = {tx_sr[FRAME_W-2:0], 1'b0};
        end
      end
      S_DONE, S_DISCARD: ;
      default: state_nx = S_IDLE;
    endcase
    if (cs_rise) begin
      state_nx = S_IDLE;
      op_nx    = '0;
      rdy_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      shift_in <= '0;
      op_code  <= '0;
      tx_sr    <= '0;
      bit_cnt  <= '0;
      dly_cnt  <= '0;
      tx_ready <= 1'b0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
    end else begin
      state    <= state_nx;
      shift_in <= shift_nx;
      op_code  <= op_nx;
      tx_sr    <= tx_nx;
      bit_cnt  <= cnt_nx;
      dly_cnt  <= dly_nx;
      tx_ready <= rdy_nx;
      miso     <= (state == S_DATA) ? tx_sr[FRAME_W-1] : 1'b0;
      miso_oe  <= ~cs_sync[1];
    end
  end

endmodule

// File: tb/tb_spi_opcode_responder.sv
// Randomized bench for spi_opcode_responder driving an SPI mode-0 master against a frame-level model.
module tb_spi_opcode_responder;

  localparam int DATA_W = 16;
  localparam int H      = 8;
`ifdef SPI_RESP_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sclk = 1'b0;
  logic              cs_n = 1'b1;
  logic              mosi = 1'b0;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] max_value = '0;
  logic [7:0]        op_code;
  logic              tx_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int tx_hi    = 0;

  spi_opcode_responder #(.DATA_W(DATA_W), .LOAD_DLY(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .max_value(max_value),
    .op_code(op_code), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // One-cycle pulses give exactly one high sample per pulse.
  always @(negedge clk) if (tx_ready) tx_hi++;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic out_bit, output logic in_bit);
    mosi = out_bit;
    wait_clk(H);
    in_bit = miso;
    sclk = 1'b1;
    wait_clk(H);
    sclk = 1'b0;
  endtask

  function automatic logic [31:0] model_word(input logic [7:0] op, input logic [DATA_W-1:0] v);
    logic [31:0] w;
    if (op < 8'h41 || op > 8'h44) return '0;
    w = 32'(v);
`ifdef SPI_RESP_PARITY_EN
    w = (w << 1) | 32'(^v);
`endif
    return w;
  endfunction

  task automatic run_frame(input logic [7:0] op, input logic [DATA_W-1:0] val, input int nbits);
    int          tx0;
    logic [31:0] rd, exp;
    logic        b;
    bit          valid;
    valid     = (op >= 8'h41 && op <= 8'h44);
    max_value = val;
    tx0       = tx_hi;
    cs_n      = 1'b0;
    for (int i = 7; i >= 0; i--) spi_bit(op[i], b);
    check("op_code_frame", 32'(op_code), 32'(op));
    check("miso_oe_frame", 32'(miso_oe), 32'd1);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(1'b0, b);
      rd = {rd[30:0], b};
    end
    exp = model_word(op, val) >> (FRAME_W - nbits);
    check("miso_data", rd, exp);
    wait_clk(4);
    check("tx_ready_pulses", 32'(tx_hi - tx0), (valid && nbits == FRAME_W) ? 32'd1 : 32'd0);
    cs_n = 1'b1;
    wait_clk(4);
    check("op_code_idle", 32'(op_code), 32'h0);
    check("miso_idle", 32'(miso), 32'h0);
    wait_clk(4);
  endtask

  initial begin
    logic [7:0]        op, opv;
    logic [DATA_W-1:0] val;
    logic              b;
    int                nb, tx0;

    wait_clk(5);
    check("rst_op_code", 32'(op_code), 32'h0);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_miso_oe", 32'(miso_oe), 32'h0);
    check("rst_tx_ready", 32'(tx_ready), 32'h0);
    reset = 1'b0;
    wait_clk(4);
    check("idle_miso_oe", 32'(miso_oe), 32'h0);

    run_frame(8'h41, 16'hBEEF, FRAME_W);
    run_frame(8'h55, 16'hA5A5, FRAME_W);
    run_frame(8'h44, 16'hC3C3, 4);

    // Reset mid-DATA with cs_n held low, then a frame that must be ignored.
    max_value = 16'h5A5A;
    opv  = 8'h44;
    cs_n = 1'b0;
    for (int i = 7; i >= 0; i--) spi_bit(opv[i], b);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
    reset = 1'b1;
    wait_clk(2);
    check("midrst_op_code", 32'(op_code), 32'h0);
    check("midrst_miso", 32'(miso), 32'h0);
    check("midrst_miso_oe", 32'(miso_oe), 32'h0);
    check("midrst_tx_ready", 32'(tx_ready), 32'h0);
    wait_clk(1);
    reset = 1'b0;
    tx0 = tx_hi;
    opv = 8'h41;
    for (int i = 7; i >= 0; i--) spi_bit(opv[i], b);
    wait_clk(4);
    check("norsm_op_code", 32'(op_code), 32'h0);
    for (int i = 0; i < 4; i++) begin
      spi_bit(1'b0, b);
      check("norsm_miso", 32'(b), 32'h0);
    end
    check("norsm_tx_ready", 32'(tx_hi - tx0), 32'h0);
    cs_n = 1'b1;
    wait_clk(6);
    run_frame(8'h42, 16'h1234, FRAME_W);

    tx0 = tx_hi;
    run_frame(8'h43, 16'h00FF, FRAME_W);
    run_frame(8'h41, 16'hFFFF, FRAME_W);
    check("b2b_pulses", 32'(tx_hi - tx0), 32'd2);

    run_frame(8'h42, 16'h0007, FRAME_W);

    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      else op = 8'h41 + 8'($urandom_range(0, 3));
      val = DATA_W'($urandom);
      nb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, FRAME_W - 1)) : FRAME_W;
      run_frame(op, val, nb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
